// File: rtl/mlu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, read selects, FSM states.
package mlu_pkg;

    localparam logic [4:0] MLU_NONE  = 5'd0;
    localparam logic [4:0] MLU_MULT  = 5'd1;
    localparam logic [4:0] MLU_MULTU = 5'd2;
    localparam logic [4:0] MLU_DIV   = 5'd3;
    localparam logic [4:0] MLU_DIVU  = 5'd4;
    localparam logic [4:0] MLU_MTHI  = 5'd5;
    localparam logic [4:0] MLU_MTLO  = 5'd6;

    localparam logic [2:0] MLU_SEL_HI = 3'd1;
    localparam logic [2:0] MLU_SEL_LO = 3'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mlu_state_t;

endpackage

// File: rtl/mlu_arith.sv
// Combinational multiply/divide datapath; produces {hi, lo} and a divide-by-zero flag.
module mlu_arith
    import mlu_pkg::*;
(
    input  logic [4:0]  mlu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic        w_is_signed;
    logic        w_neg_q;
    logic        w_neg_r;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_div_b;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_q;
    logic [31:0] w_r;
    logic [63:0] w_smul;
    logic [63:0] w_umul;

    assign w_smul = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes so 0x80000000 / -1 falls out naturally.
    assign w_is_signed = (mlu_op == MLU_DIV);
    assign w_abs_a     = (w_is_signed && a[31]) ? (32'd0 - a) : a;
    assign w_abs_b     = (w_is_signed && b[31]) ? (32'd0 - b) : b;
    assign w_div_b     = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_uq        = w_abs_a / w_div_b;
    assign w_ur        = w_abs_a % w_div_b;
    assign w_neg_q     = w_is_signed && (a[31] ^ b[31]);
    assign w_neg_r     = w_is_signed && a[31];
    assign w_q         = w_neg_q ? (32'd0 - w_uq) : w_uq;
    assign w_r         = w_neg_r ? (32'd0 - w_ur) : w_ur;

    assign div_zero = ((mlu_op == MLU_DIV) || (mlu_op == MLU_DIVU)) && (b == 32'd0);

    always_comb begin
        result = 64'd0;
        case (mlu_op)
            MLU_MULT:  result = w_smul;
            MLU_MULTU: result = w_umul;
            MLU_DIV,
            MLU_DIVU:  result = {w_r, w_q};
            default:   result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mlu.sv
// Execute-stage multiply/divide unit: HI/LO registers, pending result and fixed-latency busy FSM.
//   state   | meaning
//   ST_IDLE | no operation in flight; accepts mult/div/mthi/mtlo
//   ST_BUSY | counter running; pending result commits when it reaches 0
module mlu
    import mlu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [4:0]  mlu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  mlu_out,
    output logic [31:0] res,
    output logic        busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    mlu_state_t  r_state;
    mlu_state_t  w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_dz;
    logic [31:0] w_pend_hi_nxt;
    logic [31:0] w_pend_lo_nxt;
    logic        w_pend_dz_nxt;
    logic [63:0] w_arith;
    logic        w_div_zero;

    mlu_arith u_arith (
        .mlu_op   (mlu_op),
        .a        (a),
        .b        (b),
        .result   (w_arith),
        .div_zero (w_div_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_dz <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
            r_pend_dz <= w_pend_dz_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        w_pend_dz_nxt = r_pend_dz;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    case (mlu_op)
                        MLU_MULT, MLU_MULTU, MLU_DIV, MLU_DIVU: begin
                            w_pend_hi_nxt = w_arith[63:32];
                            w_pend_lo_nxt = w_arith[31:0];
                            w_pend_dz_nxt = w_div_zero;
                            w_state_nxt   = ST_BUSY;
                            w_cnt_nxt     = ((mlu_op == MLU_MULT) || (mlu_op == MLU_MULTU))
                                            ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        end
                        MLU_MTHI: w_hi_nxt = a;
                        MLU_MTLO: w_lo_nxt = a;
                        default:  ;
                    endcase
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = ST_IDLE;
                    if (!r_pend_dz) begin
                        w_hi_nxt = r_pend_hi;
                        w_lo_nxt = r_pend_lo;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_BUSY);

    always_comb begin
        res = 32'd0;
        case (mlu_out)
            MLU_SEL_HI: res = r_hi;
            MLU_SEL_LO: res = r_lo;
            default:    res = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mlu.sv
// Self-checking bench for mlu: directed cases plus random ops against an arithmetic model.
module tb_mlu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  mlu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  mlu_out;
    logic [31:0] res;
    logic        busy;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mlu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mlu_op  (mlu_op),
        .a       (a),
        .b       (b),
        .mlu_out (mlu_out),
        .res     (res),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [31:0] eh, input logic [31:0] el);
        mlu_out = 3'd1;
        #1;
        chk({tag, "_hi"}, res, eh);
        mlu_out = 3'd2;
        #1;
        chk({tag, "_lo"}, res, el);
    endtask

    // Reference arithmetic in 64-bit integers, straight from the op definitions.
    task automatic model_op(input logic [4:0] op, input logic [31:0] ia, input logic [31:0] ib,
                            output logic [31:0] eh, output logic [31:0] el, output int lat);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        ua = {32'd0, ia};
        ub = {32'd0, ib};
        eh = m_hi;
        el = m_lo;
        lat = 0;
        case (op)
            5'd1: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; lat = MULT_N; end
            5'd2: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; lat = MULT_N; end
            5'd3: begin
                lat = DIV_N;
                if (ib != 32'd0) begin
                    sp = sa / sb; el = sp[31:0];
                    sp = sa % sb; eh = sp[31:0];
                end
            end
            5'd4: begin
                lat = DIV_N;
                if (ib != 32'd0) begin
                    up = ua / ub; el = up[31:0];
                    up = ua % ub; eh = up[31:0];
                end
            end
            5'd5: eh = ia;
            5'd6: el = ia;
            default: ;
        endcase
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] ia,
                          input logic [31:0] ib);
        logic [31:0] eh, el;
        int lat;
        model_op(op, ia, ib, eh, el, lat);
        @(negedge clk);
        chk({tag, "_idle_before_start"}, {31'd0, busy}, 32'd0);
        start  = 1'b1;
        mlu_op = op;
        a      = ia;
        b      = ib;
        @(negedge clk);
        start  = 1'b0;
        mlu_op = 5'd0;
        a      = $urandom;
        b      = $urandom;
        for (int i = 1; i <= lat; i++) begin
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            if (i == 1) check_res({tag, "_old"}, m_hi, m_lo);
            @(negedge clk);
        end
        chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        m_hi = eh;
        m_lo = el;
        check_res(tag, m_hi, m_lo);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        reset   = 1'b1;
        start   = 1'b0;
        mlu_op  = 5'd0;
        a       = 32'd0;
        b       = 32'd0;
        mlu_out = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        check_res("reset", 32'd0, 32'd0);

        run_op("mult_m1x3", 5'd1, 32'hFFFFFFFF, 32'd3);
        chk("mult_m1x3_hi_const", m_hi, 32'hFFFFFFFF);
        run_op("multu_ffx2", 5'd2, 32'hFFFFFFFF, 32'd2);
        run_op("div_m7_2", 5'd3, 32'hFFFFFFF9, 32'd2);
        run_op("divu_7_2", 5'd4, 32'd7, 32'd2);

        // mthi then mtlo on back-to-back cycles, busy must stay low.
        @(negedge clk);
        start = 1'b1; mlu_op = 5'd5; a = 32'h12345678;
        @(negedge clk);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        mlu_op = 5'd6; a = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0; mlu_op = 5'd0;
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        m_hi = 32'h12345678;
        m_lo = 32'h9ABCDEF0;
        check_res("mthi_mtlo", 32'h12345678, 32'h9ABCDEF0);

        run_op("div_by_zero", 5'd3, 32'd1234, 32'd0);
        run_op("divu_by_zero", 5'd4, 32'd99, 32'd0);
        run_op("div_ovf", 5'd3, 32'h80000000, 32'hFFFFFFFF);

        // Op 0 and unknown op must be ignored.
        @(negedge clk);
        start = 1'b1; mlu_op = 5'd0; a = 32'hDEADBEEF;
        @(negedge clk);
        mlu_op = 5'd7;
        @(negedge clk);
        start = 1'b0; mlu_op = 5'd0;
        chk("noop_busy", {31'd0, busy}, 32'd0);
        check_res("noop", m_hi, m_lo);
        mlu_out = 3'd3;
        #1;
        chk("sel3_zero", res, 32'd0);

        for (int n = 0; n < 25; n++) begin
            rop = 5'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            run_op("rand", rop, ra, rb);
        end

        // Reset in busy cycle 4 of a divide: pending result must never appear.
        run_op("pre_reset_mult", 5'd1, 32'd1000, 32'd77);
        @(negedge clk);
        start = 1'b1; mlu_op = 5'd3; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; mlu_op = 5'd0;
        repeat (3) @(negedge clk);
        chk("mid_reset_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        check_res("mid_reset", 32'd0, 32'd0);
        repeat (DIV_N) @(negedge clk);
        chk("mid_reset_later_busy", {31'd0, busy}, 32'd0);
        check_res("mid_reset_later", 32'd0, 32'd0);

        // Reset and start together: start is dropped.
        start = 1'b1; mlu_op = 5'd5; a = 32'hCAFEF00D; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; mlu_op = 5'd1; reset = 1'b0;
        @(negedge clk);
        mlu_op = 5'd0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);
        check_res("rst_start", 32'd0, 32'd0);

        run_op("post_reset_mult", 5'd1, 32'h7FFFFFFF, 32'h7FFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
